mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
Arbitrates the single core memory port between the instruction fetch unit (IF requester) and the load/store unit (LS requester). Accepts one request at a time, drives it onto the memory port with a valid/ready handshake, waits for the response, and routes it back to the owner. Sits between IFU/LSU and the memory/bus bridge. Supports fetch cancel on redirect (branch/exception).

Parameters:
ADDR_W, 64, address width
DATA_W, 64, data width
MAX_LS_STREAK, 4, consecutive LS grants allowed while IF is waiting (starvation limit, >=1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
if_req_valid  in  1  IF fetch request
if_req_addr  in  ADDR_W  fetch address (pc)
if_req_ready  out  1  IF request accepted this cycle
if_flush  in  1  discard any outstanding/accepted IF response (redirect)
if_rsp_valid  out  1  fetch data valid (1-cycle pulse)
if_rsp_data  out  DATA_W  fetch data
ls_req_valid  in  1  LS request
ls_req_addr  in  ADDR_W  LS address
ls_req_wen  in  1  1 = store, 0 = load
ls_req_wdata  in  DATA_W  store data
ls_req_wmask  in  DATA_W/8  store byte mask
ls_req_ready  out  1  LS request accepted this cycle
ls_rsp_valid  out  1  load data / store ack (1-cycle pulse)
ls_rsp_data  out  DATA_W  load data (don't-care for store)
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  ADDR_W  latched address
mem_req_wen  out  1  latched write enable
mem_req_wdata  out  DATA_W  latched write data
mem_req_wmask  out  DATA_W/8  latched mask (all-zero for IF)
mem_rsp_valid  in  1  memory response valid
mem_rsp_data  in  DATA_W  memory response data
busy  out  1  state != IDLE

Behaviour:
- FSM states: IDLE, REQ, RSP. Owner register: IF/LS. Single outstanding transaction.
- IDLE: if any req_valid, select grantee, assert its req_ready combinationally this cycle (other ready = 0), latch addr/wen/wdata/wmask (IF: wen=0, wmask=0) and owner, go REQ. No request: stay IDLE.
- Arbitration: LS wins by default. ls_streak counter increments on an LS grant when if_req_valid=1; cleared on IF grant or LS grant with if_req_valid=0. When both valid and ls_streak==MAX_LS_STREAK, grant IF.
- REQ: mem_req_valid=1, mem_req_* = latched values, stable until mem_req_ready=1; then go RSP. req_ready outputs = 0.
- RSP: wait for mem_rsp_valid. On it: owner's rsp_valid = 1 (combinational), rsp_data = mem_rsp_data, go IDLE. New request accepted earliest next cycle (IDLE).
- mem_rsp_valid outside RSP is ignored.
- Minimum latency: accept at T, mem_req_valid from T+1, response at T+2 if memory ready/valid immediately; next accept T+3.
- if_flush: if high in the accept cycle of an IF request, or any cycle while owner=IF and state REQ/RSP, set drop flag; memory transaction still completes, if_rsp_valid suppressed. Drop flag cleared on return to IDLE. if_flush does not affect LS transactions. if_flush in IDLE with no IF grant: no effect.
- Reset (rst=0) at any time, including mid-transaction: state=IDLE, ls_streak=0, drop=0, owner=IF, latched fields=0; all outputs 0 during reset cycle and following IDLE cycle absent requests. Outstanding transaction abandoned.
- rsp_data outputs drive mem_rsp_data when valid, 0 otherwise.

Test Plan:
- Reset mid-REQ: rst=0 while mem_req_valid=1 -> next cycle mem_req_valid=0, busy=0, all ready/rsp_valid=0.
- IF fetch 0x80000000, mem ready immediately, rsp data 0x00000013 next cycle -> if_req_ready at T, mem_req_addr=0x80000000 wen=0 at T+1, if_rsp_valid=1 data 0x13 at T+2.
- Simultaneous IF and LS store (addr 0x80001000, wdata 0xDEAD, wmask 0xFF) -> LS granted first, mem_req_wen=1, ls_rsp_valid ack; IF granted next IDLE.
- Starvation: LS and IF valid continuously, MAX_LS_STREAK=4 -> grant order LS,LS,LS,LS,IF,LS...
- Memory backpressure: mem_req_ready=0 for 5 cycles -> mem_req_* held stable, no new ready asserted; response routed correctly after.
- if_flush in RSP of IF fetch -> mem_rsp_valid consumed, if_rsp_valid stays 0, FSM returns IDLE, next IF fetch 0x80000100 returns normally.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the core memory port between instruction fetch and load/store.
// One transaction in flight at a time; LS is preferred, with an IF starvation bound.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W        = 64,
  parameter int unsigned DATA_W        = 64,
  parameter int unsigned MAX_LS_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_req_ready,
  input  logic                if_flush,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_data,
  input  logic                ls_req_valid,
  input  logic [ADDR_W-1:0]   ls_req_addr,
  input  logic                ls_req_wen,
  input  logic [DATA_W-1:0]   ls_req_wdata,
  input  logic [DATA_W/8-1:0] ls_req_wmask,
  output logic                ls_req_ready,
  output logic                ls_rsp_valid,
  output logic [DATA_W-1:0]   ls_rsp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_data,
  output logic                busy
);

  localparam int unsigned STRK_W = $clog2(MAX_LS_STREAK + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP} state_e;
  typedef enum logic {OWN_IF, OWN_LS} owner_e;

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [STRK_W-1:0]   streak_q, streak_d;
  logic                drop_q, drop_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wmask_q, wmask_d;

  logic grant_ls;
  logic grant_if;
  logic dropped;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    streak_d = streak_q;
    drop_d   = drop_q;
    addr_d   = addr_q;
    wen_d    = wen_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;

    if_req_ready  = 1'b0;
    ls_req_ready  = 1'b0;
    if_rsp_valid  = 1'b0;
    ls_rsp_valid  = 1'b0;
    mem_req_valid = 1'b0;

    grant_ls = ls_req_valid && !(if_req_valid && (streak_q == STRK_W'(MAX_LS_STREAK)));
    grant_if = if_req_valid && !grant_ls;
    // A flush in the response cycle itself still suppresses the stale fetch data.
    dropped  = drop_q || ((owner_q == OWN_IF) && if_flush);

    unique case (state_q)
      S_IDLE: begin
        drop_d = 1'b0;
        if (grant_ls) begin
          ls_req_ready = 1'b1;
          owner_d      = OWN_LS;
          addr_d       = ls_req_addr;
          wen_d        = ls_req_wen;
          wdata_d      = ls_req_wdata;
          wmask_d      = ls_req_wmask;
          streak_d     = if_req_valid ? streak_q + STRK_W'(1) : '0;
          state_d      = S_REQ;
        end else if (grant_if) begin
          if_req_ready = 1'b1;
          owner_d      = OWN_IF;
          addr_d       = if_req_addr;
          wen_d        = 1'b0;
          wdata_d      = '0;
          wmask_d      = '0;
          streak_d     = '0;
          drop_d       = if_flush;
          state_d      = S_REQ;
        end
      end
      S_REQ: begin
        mem_req_valid = 1'b1;
        drop_d        = dropped;
        if (mem_req_ready) state_d = S_RSP;
      end
      S_RSP: begin
        drop_d = dropped;
        if (mem_rsp_valid) begin
          if (owner_q == OWN_LS) ls_rsp_valid = 1'b1;
          else                   if_rsp_valid = !dropped;
          drop_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    mem_req_addr  = addr_q;
    mem_req_wen   = wen_q;
    mem_req_wdata = wdata_q;
    mem_req_wmask = wmask_q;
    busy          = (state_q != S_IDLE);

    // Everything visible is forced low in the reset cycle, before the flops clear.
    if (!rst) begin
      if_req_ready  = 1'b0;
      ls_req_ready  = 1'b0;
      if_rsp_valid  = 1'b0;
      ls_rsp_valid  = 1'b0;
      mem_req_valid = 1'b0;
      mem_req_addr  = '0;
      mem_req_wen   = 1'b0;
      mem_req_wdata = '0;
      mem_req_wmask = '0;
      busy          = 1'b0;
    end

    if_rsp_data = if_rsp_valid ? mem_rsp_data : '0;
    ls_rsp_data = ls_rsp_valid ? mem_rsp_data : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      owner_q  <= OWN_IF;
      streak_q <= '0;
      drop_q   <= 1'b0;
      addr_q   <= '0;
      wen_q    <= 1'b0;
      wdata_q  <= '0;
      wmask_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
      drop_q   <= drop_d;
      addr_q   <= addr_d;
      wen_q    <= wen_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: the bench plays both requesters and the memory.
module tb_mem_bus_arbiter;

  localparam int MAX = 4;

  logic        clk;
  logic        rst;
  logic        if_req_valid;
  logic [63:0] if_req_addr;
  logic        if_req_ready;
  logic        if_flush;
  logic        if_rsp_valid;
  logic [63:0] if_rsp_data;
  logic        ls_req_valid;
  logic [63:0] ls_req_addr;
  logic        ls_req_wen;
  logic [63:0] ls_req_wdata;
  logic [7:0]  ls_req_wmask;
  logic        ls_req_ready;
  logic        ls_rsp_valid;
  logic [63:0] ls_rsp_data;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_req_wen;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_data;
  logic        busy;

  mem_bus_arbiter #(.ADDR_W(64), .DATA_W(64), .MAX_LS_STREAK(MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_flush(if_flush), .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .ls_req_valid(ls_req_valid), .ls_req_addr(ls_req_addr), .ls_req_wen(ls_req_wen),
    .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask), .ls_req_ready(ls_req_ready),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .busy(busy)
  );

  typedef struct { bit ls; int unsigned cyc; } acc_t;
  typedef struct { logic [63:0] addr; logic wen; logic [63:0] wdata; logic [7:0] wmask; int unsigned cyc; } mem_t;
  typedef struct { bit ls; logic [63:0] data; int unsigned cyc; } rsp_t;

  acc_t acc_q[$];
  mem_t mem_q[$];
  rsp_t rsp_q[$];

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: DUT output with no expected entry (cycle %0d)", name, cyc);
  endtask

  // Grant monitor
  always @(negedge clk) begin
    acc_t a;
    if (if_req_ready || ls_req_ready) begin
      if (acc_q.size() == 0) unexpected("grant");
      else begin
        a = acc_q.pop_front();
        chk("grant_ls", {63'd0, ls_req_ready}, {63'd0, a.ls});
        chk("grant_if", {63'd0, if_req_ready}, {63'd0, !a.ls});
        chk("grant_cycle", 64'(cyc), 64'(a.cyc));
        chk("busy_at_grant", {63'd0, busy}, 64'd0);
      end
    end
  end

  // Memory request monitor: fields must hold steady until the handshake
  always @(negedge clk) begin
    mem_t m;
    if (mem_req_valid) begin
      if (mem_q.size() == 0) unexpected("mem_req");
      else begin
        m = mem_q[0];
        chk("mem_addr", mem_req_addr, m.addr);
        chk("mem_wen", {63'd0, mem_req_wen}, {63'd0, m.wen});
        chk("mem_wdata", mem_req_wdata, m.wdata);
        chk("mem_wmask", {56'd0, mem_req_wmask}, {56'd0, m.wmask});
        chk("busy_in_req", {63'd0, busy}, 64'd1);
        if (mem_req_ready) begin
          chk("mem_hs_cycle", 64'(cyc), 64'(m.cyc));
          void'(mem_q.pop_front());
        end
      end
    end
  end

  // Response monitor
  always @(negedge clk) begin
    rsp_t r;
    if (if_rsp_valid || ls_rsp_valid) begin
      if (rsp_q.size() == 0) unexpected("rsp");
      else begin
        r = rsp_q.pop_front();
        chk("rsp_ls", {63'd0, ls_rsp_valid}, {63'd0, r.ls});
        chk("rsp_if", {63'd0, if_rsp_valid}, {63'd0, !r.ls});
        chk("rsp_data", ls_rsp_valid ? ls_rsp_data : if_rsp_data, r.data);
        chk("rsp_cycle", 64'(cyc), 64'(r.cyc));
      end
    end
    if (mem_rsp_valid) begin
      if (!if_rsp_valid) chk("if_rsp_data_idle", if_rsp_data, 64'd0);
      if (!ls_rsp_valid) chk("ls_rsp_data_idle", ls_rsp_data, 64'd0);
    end
  end

  // Requester state and arbitration reference
  bit          if_pend, ls_pend;
  logic [63:0] if_a, ls_a, ls_wd;
  logic        ls_we;
  logic [7:0]  ls_wm;
  int          streak;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_reqs;
    if_req_valid = if_pend;
    if_req_addr  = if_a;
    ls_req_valid = ls_pend;
    ls_req_addr  = ls_a;
    ls_req_wen   = ls_we;
    ls_req_wdata = ls_wd;
    ls_req_wmask = ls_wm;
  endtask

  task automatic gen(input int pct);
    if (!if_pend && $urandom_range(99) < pct) begin
      if_pend = 1'b1;
      if_a    = {$urandom, $urandom} & ~64'h3;
    end
    if (!ls_pend && $urandom_range(99) < pct) begin
      ls_pend = 1'b1;
      ls_a    = {$urandom, $urandom} & ~64'h7;
      ls_we   = $urandom_range(1);
      ls_wd   = {$urandom, $urandom};
      ls_wm   = 8'($urandom);
    end
    drive_reqs();
  endtask

  // fmode: 0 random flushes, 1 flush only while awaiting the response, 2 never
  function automatic bit fl(input int fmode, input bit rsp_phase);
    if (fmode == 0) return ($urandom_range(7) == 0);
    if (fmode == 1) return rsp_phase;
    return 1'b0;
  endfunction

  // One arbitration slot: either an idle cycle or a full transaction with
  // d cycles of request backpressure and e cycles of response latency.
  task automatic txn(input int d, input int e, input logic [63:0] rd, input int fmode, input int pct);
    bit   gl, drop;
    mem_t m;
    acc_t a;
    rsp_t r;
    gen(pct);
    mem_req_ready = $urandom_range(1);
    mem_rsp_valid = $urandom_range(1);
    mem_rsp_data  = {$urandom, $urandom};
    if (!if_pend && !ls_pend) begin
      if_flush = fl(fmode, 1'b0);
      tick();
      return;
    end
    gl = ls_pend && !(if_pend && streak == MAX);
    if (gl) streak = if_pend ? streak + 1 : 0;
    else    streak = 0;
    a.ls = gl; a.cyc = cyc;
    acc_q.push_back(a);
    m.addr  = gl ? ls_a : if_a;
    m.wen   = gl ? ls_we : 1'b0;
    m.wdata = gl ? ls_wd : 64'd0;
    m.wmask = gl ? ls_wm : 8'd0;
    m.cyc   = cyc + 1 + d;
    mem_q.push_back(m);
    if_flush = fl(fmode, 1'b0);
    drop     = !gl && if_flush;
    tick();
    if (gl) ls_pend = 1'b0;
    else    if_pend = 1'b0;
    for (int i = 0; i <= d; i++) begin
      gen(pct / 4);
      mem_req_ready = (i == d);
      mem_rsp_valid = $urandom_range(1);
      mem_rsp_data  = {$urandom, $urandom};
      if_flush      = fl(fmode, 1'b0);
      drop          = drop || (!gl && if_flush);
      tick();
    end
    for (int i = 0; i <= e; i++) begin
      gen(pct / 4);
      mem_req_ready = $urandom_range(1);
      mem_rsp_valid = (i == e);
      mem_rsp_data  = (i == e) ? rd : {$urandom, $urandom};
      if_flush      = fl(fmode, 1'b1);
      drop          = drop || (!gl && if_flush);
      if (i == e && (gl || !drop)) begin
        r.ls = gl; r.data = rd; r.cyc = cyc;
        rsp_q.push_back(r);
      end
      tick();
    end
    mem_rsp_valid = 1'b0;
    if_flush      = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_mem_req_valid"}, {63'd0, mem_req_valid}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_if_ready"}, {63'd0, if_req_ready}, 64'd0);
    chk({tag, "_ls_ready"}, {63'd0, ls_req_ready}, 64'd0);
    chk({tag, "_if_rsp_valid"}, {63'd0, if_rsp_valid}, 64'd0);
    chk({tag, "_ls_rsp_valid"}, {63'd0, ls_rsp_valid}, 64'd0);
    chk({tag, "_mem_req_addr"}, mem_req_addr, 64'd0);
  endtask

  initial begin
    mem_t m;
    acc_t a;
    rst = 1'b0; if_flush = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    if_pend = 1'b0; ls_pend = 1'b0; streak = 0;
    if_a = '0; ls_a = '0; ls_wd = '0; ls_we = 1'b0; ls_wm = '0;
    drive_reqs();
    tick();
    if_req_valid = 1'b1; ls_req_valid = 1'b1;
    #1 chk_quiet("reset");
    tick();
    rst = 1'b1;
    drive_reqs();
    #1 chk_quiet("post_reset_idle");
    tick();

    // Plain fetch with immediate memory
    if_pend = 1'b1; if_a = 64'h8000_0000;
    txn(0, 0, 64'h13, 2, 0);

    // Simultaneous store and fetch: store first, fetch in the following slot
    if_pend = 1'b1; if_a = 64'h8000_0040;
    ls_pend = 1'b1; ls_a = 64'h8000_1000; ls_we = 1'b1; ls_wd = 64'hDEAD; ls_wm = 8'hFF;
    txn(0, 0, 64'h1111, 2, 0);
    txn(0, 0, 64'h2222, 2, 0);

    // Load with five cycles of request backpressure
    ls_pend = 1'b1; ls_a = 64'h8000_2008; ls_we = 1'b0; ls_wd = 64'h0; ls_wm = 8'h00;
    txn(5, 2, 64'hCAFE_F00D, 2, 0);

    // Fetch flushed while waiting for data, then a clean fetch
    if_pend = 1'b1; if_a = 64'h8000_0080;
    txn(0, 1, 64'hBAD0, 1, 0);
    if_pend = 1'b1; if_a = 64'h8000_0100;
    txn(0, 0, 64'h600D, 2, 0);

    // Both requesters saturated: LS streak bound lets IF in every fifth slot
    for (int i = 0; i < 15; i++)
      txn($urandom_range(1), $urandom_range(1), {$urandom, $urandom}, 2, 100);

    for (int i = 0; i < 250; i++)
      txn($urandom_range(3), $urandom_range(3), {$urandom, $urandom}, 0, 60);

    // Drain and drop any pending requests before the mid-transaction reset
    if_pend = 1'b0; ls_pend = 1'b0;
    txn(0, 0, 64'd0, 2, 0);

    if_pend = 1'b1; if_a = 64'h8000_3000;
    drive_reqs();
    streak = 0;
    a.ls = 1'b0; a.cyc = cyc;
    acc_q.push_back(a);
    m.addr = if_a; m.wen = 1'b0; m.wdata = '0; m.wmask = '0; m.cyc = 0;
    mem_q.push_back(m);
    tick();
    if_pend = 1'b0;
    mem_req_ready = 1'b0;
    drive_reqs();
    #1 chk("pre_reset_mem_req_valid", {63'd0, mem_req_valid}, 64'd1);
    rst = 1'b0;
    mem_req_ready = 1'b1;
    if_req_valid = 1'b1;
    #1 chk_quiet("mid_reset");
    void'(mem_q.pop_front());
    tick();
    rst = 1'b1;
    if_req_valid = 1'b0;
    mem_req_ready = 1'b0;
    #1 chk_quiet("after_mid_reset");
    tick();

    if_pend = 1'b1; if_a = 64'h8000_0200;
    txn(1, 1, 64'h0123_4567_89AB_CDEF, 2, 0);
    ls_pend = 1'b1; ls_a = 64'h8000_4000; ls_we = 1'b1; ls_wd = 64'h55; ls_wm = 8'h0F;
    txn(0, 0, 64'h77, 2, 0);
    txn(0, 0, 64'd0, 2, 0);
    tick();
    tick();

    chk("acc_q_drained", 64'(acc_q.size()), 64'd0);
    chk("mem_q_drained", 64'(mem_q.size()), 64'd0);
    chk("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
